// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and width helpers for fifo_wr_arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Producer index width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int burst_w(input int mb);
    return (mb >= 1) ? $clog2(mb + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority first-one finder starting at i_base
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_base,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  // Rotate so that bit 0 of rot corresponds to producer i_base.
  assign dbl     = {i_req, i_req} >> i_base;
  assign rot     = dbl[N-1:0];
  assign o_valid = |rot;

  always_comb begin
    o_idx = '0;
    sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, i_base} + (W + 1)'(i);
        if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
        o_idx = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-locking write arbiter in front of one FIFO
// Optional FIFO_SRC_TAG_EN prepends the winner index to o_fifo_data.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16,
  localparam int ID_W     = id_w(NUM_REQ),
  localparam int BW       = burst_w(MAX_BURST),
`ifdef FIFO_SRC_TAG_EN
  localparam int OUT_W    = SIZE_DATA + ID_W
`else
  localparam int OUT_W    = SIZE_DATA
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_data,
  output logic [NUM_REQ-1:0]           o_gnt,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
  output logic [OUT_W-1:0]             o_fifo_data,
  input  logic                         i_cnt_clr,
  output logic [CNT_WIDTH-1:0]         o_wr_count
);

  arb_state_e           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      owner;
  logic [BW-1:0]        burst_cnt;
  logic [CNT_WIDTH-1:0] wr_count;

  logic                 hold;
  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      next_ptr;
  logic                 write;
  logic                 write_out;
  logic [SIZE_DATA-1:0] sel_data;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .i_req   (i_req),
    .i_base  (rr_ptr),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  assign hold      = (state == ARB_LOCK) && i_req[owner] && (burst_cnt < BW'(MAX_BURST));
  assign winner    = hold ? owner : pick_idx;
  assign write     = (hold || pick_valid) && !i_fifo_full;
  assign write_out = write && i_rst_n;
  assign next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) sel_data = i_data[k*SIZE_DATA +: SIZE_DATA];
    end
  end

  assign o_gnt        = write_out ? (NUM_REQ'(1) << winner) : '0;
  assign o_fifo_wr_en = write_out;
`ifdef FIFO_SRC_TAG_EN
  assign o_fifo_data  = {winner, sel_data};
`else
  assign o_fifo_data  = sel_data;
`endif
  assign o_wr_count   = wr_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wr_count  <= '0;
    end else begin
      if (write) begin
        if (hold) begin
          burst_cnt <= burst_cnt + BW'(1);
        end else begin
          // A fresh grant, even to the previous owner after an exhausted burst.
          owner     <= winner;
          burst_cnt <= BW'(1);
          rr_ptr    <= next_ptr;
          state     <= (MAX_BURST > 1) ? ARB_LOCK : ARB_IDLE;
        end
      end else if (!hold) begin
        state     <= ARB_IDLE;
        burst_cnt <= '0;
      end

      if (i_cnt_clr) begin
        wr_count <= '0;
      end else if (write && !(&wr_count)) begin
        wr_count <= wr_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR   = 4;
  localparam int SD   = 8;
  localparam int IDW  = id_w(NR);
`ifdef FIFO_SRC_TAG_EN
  localparam int OW   = SD + IDW;
`else
  localparam int OW   = SD;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*SD-1:0]  data;
  logic              full;
  logic              clr;

  logic [NR-1:0]     gnt_a, gnt_b;
  logic              wr_en_a, wr_en_b;
  logic [OW-1:0]     fdata_a, fdata_b;
  logic [15:0]       cnt_a;
  logic [2:0]        cnt_b;

  int checks   = 0;
  int failures = 0;

  logic [SD-1:0] dat [NR];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .SIZE_DATA(SD), .MAX_BURST(4), .CNT_WIDTH(16)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .o_gnt(gnt_a),
    .i_fifo_full(full), .o_fifo_wr_en(wr_en_a), .o_fifo_data(fdata_a),
    .i_cnt_clr(clr), .o_wr_count(cnt_a)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .SIZE_DATA(SD), .MAX_BURST(1), .CNT_WIDTH(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .o_gnt(gnt_b),
    .i_fifo_full(full), .o_fifo_wr_en(wr_en_b), .o_fifo_data(fdata_b),
    .i_cnt_clr(clr), .o_wr_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int p);
    logic [31:0] w;
`ifdef FIFO_SRC_TAG_EN
    w = 32'({IDW'(p), dat[p]});
`else
    w = 32'(dat[p]);
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    clr   = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
    data  = {dat[3], dat[2], dat[1], dat[0]};
    rst_n = 1'b0;
    req   = 4'b1111;
    full  = 1'b0;
    clr   = 1'b0;

    // Reset state and reset in the middle of a burst
    #1;
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_wr_en", 32'(wr_en_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'h0);
    tick();
    rst_n = 1'b1;
    #1; chk("t1_c0_gnt", 32'(gnt_a), 32'b0001);
    tick();
    #1; chk("t1_c1_gnt", 32'(gnt_a), 32'b0001);
    tick();
    #1; chk("t1_count_pre", 32'(cnt_a), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_gnt", 32'(gnt_a), 32'h0);
    chk("t1_rst_wr_en", 32'(wr_en_a), 32'h0);
    chk("t1_rst_count", 32'(cnt_a), 32'h0);
    tick();
    rst_n = 1'b1;
    #1; chk("t1_after_gnt", 32'(gnt_a), 32'b0001);
    tick();

    // Burst fairness between producers 0 and 1
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t2_gnt_%0d", i), 32'(gnt_a), (((i / 4) % 2) == 0) ? 32'b0001 : 32'b0010);
      chk($sformatf("t2_data_%0d", i), 32'(fdata_a), exp_word((i / 4) % 2));
      tick();
    end
    req = '0;
    #1; chk("t2_count", 32'(cnt_a), 32'd16);
    chk("t2_idle_wr_en", 32'(wr_en_a), 32'h0);

    // Early release re-arbitrates without a bubble
    do_reset();
    req = 4'b0101;
    #1; chk("t3_c0_gnt", 32'(gnt_a), 32'b0001);
    tick();
    #1; chk("t3_c1_gnt", 32'(gnt_a), 32'b0001);
    tick();
    req = 4'b0100;
    #1; chk("t3_c2_gnt", 32'(gnt_a), 32'b0100);
    tick();
    req = 4'b1011;
    #1; chk("t3_rrptr3_gnt", 32'(gnt_a), 32'b1000);
    tick();

    // FIFO full freezes the owner's burst
    do_reset();
    req = 4'b0010;
    #1; chk("t4_c0_gnt", 32'(gnt_a), 32'b0010);
    tick();
    tick();
    req  = 4'b1111;
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_full_gnt_%0d", i), 32'(gnt_a), 32'h0);
      chk($sformatf("t4_full_wr_en_%0d", i), 32'(wr_en_a), 32'h0);
      chk($sformatf("t4_full_count_%0d", i), 32'(cnt_a), 32'd2);
      tick();
    end
    full = 1'b0;
    #1; chk("t4_resume0_gnt", 32'(gnt_a), 32'b0010);
    tick();
    #1; chk("t4_resume1_gnt", 32'(gnt_a), 32'b0010);
    tick();
    #1; chk("t4_next_gnt", 32'(gnt_a), 32'b0100);
    tick();
    #1; chk("t4_count", 32'(cnt_a), 32'd5);

    // Wrap-around after producer 3's burst
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("t5_p3_gnt_%0d", i), 32'(gnt_a), 32'b1000);
      tick();
    end
    req = 4'b1001;
    #1; chk("t5_wrap_gnt", 32'(gnt_a), 32'b0001);
    tick();

    // MAX_BURST=1 word-level round-robin, and counter saturation on a 3-bit counter
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1; chk($sformatf("t5_b1_gnt_%0d", i), 32'(gnt_b), 32'(4'b0001 << (i % 4)));
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    #1; chk("t5_b1_count_sat", 32'(cnt_b), 32'd7);

    // Counter clear wins over a write; data path for producer 2
    do_reset();
    req = 4'b0100;
    tick();
    #1; chk("t6_count1", 32'(cnt_a), 32'd1);
    clr = 1'b1;
    #1; chk("t6_clr_gnt", 32'(gnt_a), 32'b0100);
    tick();
    clr = 1'b0;
    #1; chk("t6_clr_count", 32'(cnt_a), 32'd0);
    chk("t6_data_p2", 32'(fdata_a), exp_word(2));
`ifdef FIFO_SRC_TAG_EN
    chk("t6_tag_word", 32'(fdata_a), 32'b10_1010_0101);
`endif
    tick();
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
